// File: rtl/tinker_dmem_ctrl.sv
// Handshaked data memory for the tinker MEM stage: one outstanding request,
// fixed access latency, per-byte write enables and bounds/alignment errors.
module tinker_dmem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH_BYTES = 524288,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;

  logic accept, access, handshake;
  logic oob, misaligned, err;
  logic [ADDR_W:0] end_addr;

  logic [7:0] mem [DEPTH_BYTES];

  function automatic logic [IDX_W-1:0] byte_idx(input logic [ADDR_W-1:0] base,
                                                input int unsigned off);
    logic [ADDR_W-1:0] a;
    a = base + ADDR_W'(off);
    return a[IDX_W-1:0];
  endfunction

  // End address is one bit wider than the address so the bounds test cannot wrap.
  assign end_addr   = {1'b0, addr_q} + (ADDR_W+1)'(NB);
  assign oob        = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
  assign misaligned = (ALIGN_CHECK != 0) && ((addr_q % ADDR_W'(NB)) != '0);
  assign err        = oob || misaligned;

  assign req_ready = reset_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_n   = 4'(LATENCY - 1);
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          access  = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          handshake = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= '0;
        if (!err && !we_q) begin
          for (int unsigned i = 0; i < NB; i++) begin
            rsp_rdata[8*i +: 8] <= mem[byte_idx(addr_q, i)];
          end
        end
      end else if (handshake) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Array has no reset; an async reset forces IDLE, so a dropped write never commits.
  always_ff @(posedge clk) begin
    if (access && !err && we_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be_q[i]) mem[byte_idx(addr_q, i)] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
